// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU write-back datapath.
// Flag bit positions index the {N, Z, C} flags vector.
package alu_pkg;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 3;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [AWIDTH-1:0] addr;
    logic              wb;
    logic              carry;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO; slot0 is always the head, slot1 the second entry.
// Caller must not push when count==2 nor pop when count==0.
module wb_fifo2
  import alu_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  T           din,
  output T           head,
  output T           tail,
  output logic [1:0] count
);

  T slot0;
  T slot1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          // Leave slot0 untouched when draining to empty so outputs stay stable.
          if (count == 2'd2) slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: slot0 <= din;
        default: ;
      endcase
    end
  end

  assign head = slot0;
  assign tail = (count == 2'd2) ? slot1 : slot0;

endmodule

// File: rtl/alu_writeback.sv
// Write-back stage: buffers ALU results and commits them to the register file.
// Define ALU_WB_FLAGS_EN to add the {N, Z, C} flags output and carry storage.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DWIDTH = alu_pkg::DWIDTH,
  parameter int AWIDTH = alu_pkg::AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic              alu_carry,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic              wb_req,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic              busy,
  output logic              en_out,
  output logic              fwd_valid,
  output logic [AWIDTH-1:0] fwd_addr,
`ifdef ALU_WB_FLAGS_EN
  output logic [DWIDTH-1:0] fwd_data,
  output logic [2:0]        flags
`else
  output logic [DWIDTH-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [AWIDTH-1:0] addr;
    logic              wb;
    logic              carry;
  } ent_t;

  ent_t       din;
  ent_t       head;
  ent_t       tail;
  logic [1:0] count;
  logic       head_v;
  logic       push;
  logic       pop;

  assign din.data = alu_out;
  assign din.addr = rd_addr;
  assign din.wb   = wb_req;
`ifdef ALU_WB_FLAGS_EN
  assign din.carry = alu_carry;
`else
  assign din.carry = 1'b0;
`endif

  assign head_v = (count != 2'd0);
  assign busy   = (count == 2'd2);
  assign push   = en_in & ~busy;
  // Flags-only entries never need the port, so they retire at once.
  assign pop    = head_v & (rf_ready | ~head.wb);

  wb_fifo2 #(
    .T(ent_t)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (din),
    .head (head),
    .tail (tail),
    .count(count)
  );

  assign rf_we     = head_v & head.wb;
  assign rf_waddr  = head.addr;
  assign rf_wdata  = head.data;
  assign fwd_valid = head_v & tail.wb;
  assign fwd_addr  = tail.addr;
  assign fwd_data  = tail.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_out <= 1'b0;
    else en_out <= pop;
  end

`ifdef ALU_WB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (pop) begin
      flags[FLAG_N] <= head.data[DWIDTH-1];
      flags[FLAG_Z] <= (head.data == '0);
      flags[FLAG_C] <= head.carry;
    end
  end

  logic unused_bits;
  assign unused_bits = tail.carry;
`else
  logic unused_bits;
  assign unused_bits = ^{alu_carry, head.carry, tail.carry};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a queue-based reference model.
// Build with ALU_WB_FLAGS_EN defined to also check the flags output.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_in = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_carry = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        wb_req = 1'b0;
  logic        rf_ready = 1'b0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy;
  logic        en_out;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
`ifdef ALU_WB_FLAGS_EN
  logic [2:0]  flags;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_writeback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_in    (en_in),
    .alu_out  (alu_out),
    .alu_carry(alu_carry),
    .rd_addr  (rd_addr),
    .wb_req   (wb_req),
    .rf_ready (rf_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy),
    .en_out   (en_out),
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
`ifdef ALU_WB_FLAGS_EN
    .fwd_data (fwd_data),
    .flags    (flags)
`else
    .fwd_data (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  addr;
    logic        wb;
    logic        carry;
  } item_t;

  item_t      q[$];
  logic       m_en_out = 1'b0;
  logic [2:0] m_flags = 3'b000;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending results.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_en_out = 1'b0;
      m_flags  = 3'b000;
    end else begin
      item_t it;
      logic popped;
      logic pushed;
      popped = (q.size() > 0) && (rf_ready || !q[0].wb);
      pushed = en_in && (q.size() < 2);
      m_en_out = popped;
      if (popped) begin
        m_flags = {q[0].data[15], q[0].data == 16'h0, q[0].carry};
        void'(q.pop_front());
      end
      if (pushed) begin
        it.data  = alu_out;
        it.addr  = rd_addr;
        it.wb    = wb_req;
        it.carry = alu_carry;
        q.push_back(it);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_we;
    logic e_fv;
    e_we = (q.size() > 0) && q[0].wb;
    e_fv = (q.size() > 0) && q[q.size()-1].wb;
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("busy", 32'(busy), 32'(q.size() == 2));
    chk("en_out", 32'(en_out), 32'(m_en_out));
    chk("fwd_valid", 32'(fwd_valid), 32'(e_fv));
    if (e_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(q[0].addr));
      chk("rf_wdata", 32'(rf_wdata), 32'(q[0].data));
    end
    if (e_fv) begin
      chk("fwd_addr", 32'(fwd_addr), 32'(q[q.size()-1].addr));
      chk("fwd_data", 32'(fwd_data), 32'(q[q.size()-1].data));
    end
`ifdef ALU_WB_FLAGS_EN
    chk("flags", 32'(flags), 32'(m_flags));
`endif
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [15:0] d,
                       input logic [2:0] a, input logic w, input logic c);
    en_in     = e;
    alu_out   = d;
    rd_addr   = a;
    wb_req    = w;
    alu_carry = c;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc();
    cyc();
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", 32'(rf_wdata), 32'h0);
    chk("rst_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'h0);
    chk("rst_busy_en", 32'({busy, en_out}), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single write, minimum latency
    rf_ready = 1'b1;
    drive(1'b1, 16'h1234, 3'd3, 1'b1, 1'b0);
    cyc();
    idle();
    chk("t1_we", 32'(rf_we), 32'h1);
    chk("t1_addr", 32'(rf_waddr), 32'h3);
    chk("t1_data", 32'(rf_wdata), 32'h1234);
    chk("t1_en_early", 32'(en_out), 32'h0);
    cyc();
    chk("t1_en", 32'(en_out), 32'h1);
    chk("t1_we_off", 32'(rf_we), 32'h0);
    cyc();
    chk("t1_en_off", 32'(en_out), 32'h0);

    // Stall until full, ignored third push, then ordered drain
    rf_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 3'd1, 1'b1, 1'b0);
    cyc();
    chk("t2_busy1", 32'(busy), 32'h0);
    drive(1'b1, 16'h5555, 3'd2, 1'b1, 1'b0);
    cyc();
    chk("t2_busy2", 32'(busy), 32'h1);
    drive(1'b1, 16'h7777, 3'd5, 1'b1, 1'b0);
    cyc();
    idle();
    chk("t2_still_busy", 32'(busy), 32'h1);
    chk("t2_head", 32'({rf_waddr, rf_wdata}), {13'h0, 3'd1, 16'hAAAA});
    chk("t2_tail", 32'({fwd_addr, fwd_data}), {13'h0, 3'd2, 16'h5555});
    rf_ready = 1'b1;
    cyc();
    chk("t2_busy_fall", 32'(busy), 32'h0);
    chk("t2_second", 32'({rf_waddr, rf_wdata}), {13'h0, 3'd2, 16'h5555});
    chk("t2_en1", 32'(en_out), 32'h1);
    cyc();
    chk("t2_en2", 32'(en_out), 32'h1);
    chk("t2_empty", 32'(rf_we), 32'h0);
    cyc();

    // Forwarding: youngest value for a repeated address wins
    rf_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'd4, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 16'h0002, 3'd4, 1'b1, 1'b0);
    cyc();
    idle();
    chk("t3_fv", 32'(fwd_valid), 32'h1);
    chk("t3_fa", 32'(fwd_addr), 32'h4);
    chk("t3_fd", 32'(fwd_data), 32'h0002);
    rf_ready = 1'b1;
    cyc();
    cyc();
    cyc();

    // Flags-only entry retires without the port
    rf_ready = 1'b0;
    drive(1'b1, 16'h0000, 3'd6, 1'b0, 1'b1);
    cyc();
    idle();
    chk("t4_no_we", 32'(rf_we), 32'h0);
    chk("t4_no_fwd", 32'(fwd_valid), 32'h0);
    cyc();
    chk("t4_en", 32'(en_out), 32'h1);
`ifdef ALU_WB_FLAGS_EN
    chk("t4_flags", 32'(flags), 32'h3);
`endif
    cyc();
    chk("t4_en_off", 32'(en_out), 32'h0);

    // Back-to-back pushes at full throughput
    rf_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h8000 + 16'(i * 16'h1111), 3'(i), 1'b1, 1'(i));
      cyc();
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_data", 32'(rf_wdata), 32'(16'h8000 + 16'(i * 16'h1111)));
    end
    idle();
    cyc();
    chk("t5_last_en", 32'(en_out), 32'h1);
    cyc();

    // Reset while full flushes pending writes
    rf_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 3'd7, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 16'hCAFE, 3'd6, 1'b1, 1'b0);
    cyc();
    idle();
    chk("t6_full", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    cyc();
    chk("t6_rst_out", 32'({rf_we, busy, en_out, fwd_valid}), 32'h0);
    chk("t6_rst_bus", 32'({rf_waddr, rf_wdata}), 32'h0);
    chk("t6_rst_fwd", 32'({fwd_addr, fwd_data}), 32'h0);
    rst_n = 1'b1;
    rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_we", 32'(rf_we), 32'h0);
      chk("t6_no_en", 32'(en_out), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
